inst_prefetch_queue: RTL
========================

Name: inst_prefetch_queue

Overview:
- Prefetch buffer between instruction memory and the core's IF stage.
- Issues sequential word-address fetches over a req/ack memory handshake and buffers returned instructions with their PCs in a small FIFO.
- Presents the head entry to the fetch stage through a valid/ready handshake.
- On a taken branch or jump (redirect), discards queued and in-flight fetches and restarts at the redirect target.
- Stops fetching once the halt word 32'hffffffff has been fetched.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
RESET_PC, 32'h0, first fetch address after reset.
HALT_WORD, 32'hffffffff, instruction value that stops further fetching.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
redirect  input  1  flush pulse from EX stage; taken branch or jump
redirect_pc  input  32  new fetch address, word-addressed
mem_req  output  1  fetch request; held high until mem_ack
mem_addr  output  32  fetch word address; stable while mem_req is high
mem_ack  input  1  one-cycle response strobe; mem_rdata valid in the same cycle
mem_rdata  input  32  fetched instruction
out_valid  output  1  head entry available
out_inst  output  32  head instruction
out_pc  output  32  PC of head instruction
out_ready  input  1  consumer accepts head this cycle
halted  output  1  halt word fetched and enqueued; fetching stopped

Behaviour:
- Reset values: mem_req=0, mem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, halted=0, fetch_pc=RESET_PC, queue empty, state=IDLE.
- Addressing: word address; next fetch_pc = fetch_pc+1 with modulo 2^32 wrap (32'hffffffff -> 0).
- States: IDLE, REQ, DRAIN, HALT.
  - IDLE: if the queue has a free slot, counting slots reserved by outstanding requests, assert mem_req with mem_addr=fetch_pc and go to REQ next cycle. One outstanding request maximum.
  - REQ: hold mem_req/mem_addr until mem_ack.
    - On mem_ack: enqueue {mem_rdata, mem_addr}, fetch_pc += 1, deassert mem_req.
    - If mem_rdata==HALT_WORD, go to HALT; otherwise go to IDLE.
    - Back-to-back issue allowed: mem_req may reassert the cycle after ack.
  - DRAIN: entered when redirect arrives while in REQ without a same-cycle ack. Keep mem_req high until mem_ack, discard that data, then go to IDLE. The new target is already loaded into fetch_pc.
  - HALT: no requests; halted=1; the queue still drains to the consumer. Leave only on redirect (-> IDLE, halted=0) or reset.
- Redirect, all states:
  - Same cycle: queue flushed (count=0, pointers reset); out_valid=0 from the next cycle; fetch_pc <= redirect_pc.
  - A same-cycle mem_ack is discarded.
  - A same-cycle out_ready pop is ignored; the consumer also flushes.
  - Redirect in DRAIN: update fetch_pc and stay in DRAIN.
- Output handshake:
  - out_valid = count!=0; out_inst/out_pc are registered head values.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop when full is legal: a pop frees a slot for the same-cycle ack, because the request was only issued with a reserved slot.
- Latency: ack at cycle N -> out_valid at N+1 when the queue was empty. No combinational mem->out path.
- Zero-latency ack is not supported: mem_ack is ignored while mem_req=0.
- Reset mid-transfer: all state cleared asynchronously; the memory side must drop any pending ack.
- Overflow and underflow are impossible by construction. Covered by assertions: push only when count<DEPTH; pop only when count>0.

Optional Feature:
- Macro: INST_PREFETCH_QUEUE_STATS_EN.
- Defined: adds output ports stat_fetches[31:0] and stat_flushes[31:0], both reset to 0.
  - stat_fetches increments on every accepted (non-discarded) ack.
  - stat_flushes increments on every redirect cycle.
  - Both saturate at 32'hffffffff.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (risc_pkg): XLEN=32, HALT_WORD constant, fetch state enum {IDLE,REQ,DRAIN,HALT}.
- One sub-module: prefetch_fifo.
  - Storage DEPTH x 64 ({pc,inst}) with push, pop and flush.
  - Outputs count, head, full, empty.
- FSM and address logic live in the top module.

Test Plan:
- Reset then 1-cycle ack memory returning inst=addr+32'h100, out_ready=1 -> mem_addr 0,1,2...; out_pc 0,1,2 with out_inst 32'h100,32'h101,32'h102 in order; first out_valid 1 cycle after the first ack.
- out_ready=0, DEPTH=4 -> exactly 4 acks then mem_req stays 0. Raise out_ready -> request resumes at addr 4.
- Redirect to 32'h40 while a request for addr 3 awaits ack (ack delayed 3 cycles) -> DRAIN; addr-3 data discarded; next request addr 32'h40; out_pc of the next valid entry is 32'h40.
- Memory returns 32'hffffffff at addr 5 -> entry enqueued; halted=1; no further mem_req. Redirect to 0 -> halted=0; fetch restarts at 0.
- Fetch_pc 32'hfffffffe with two fetches -> addresses 32'hfffffffe, 32'hffffffff, then 0 (wrap).
- Assert rst_n low mid-REQ -> all outputs at reset values immediately; first request after release at RESET_PC.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the instruction prefetch queue.
// Contents: XLEN, the default halt word, the fetch FSM state enum and a
// saturating 32-bit increment helper used by the optional statistics counters.
package risc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_HALT_WORD = 32'hffff_ffff;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hffff_ffff) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Bundle of the prefetch queue's handshake signals.
//   redirect/redirect_pc           : flush request and new word address from EX
//   mem_req/mem_addr/mem_ack/mem_rdata : req/ack instruction memory port
//   out_valid/out_inst/out_pc/out_ready : valid/ready port towards IF
//   halted                         : halt word fetched, fetching stopped
// Modport master is the prefetch queue; slave is its environment.
interface inst_prefetch_queue_if;
  import risc_pkg::*;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;
  logic            halted;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_inst, out_pc, halted
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_inst, out_pc, halted
  );

endinterface

// File: rtl/prefetch_fifo.sv
// DEPTH-entry FIFO holding {pc, inst} pairs for the prefetch queue.
// Ports: clk, rst_n (async, active-low), push/din, pop, flush (clears
// pointers and count; same-cycle push/pop ignored), head (entry at the read
// pointer, read straight from storage registers), count, full, empty.
// A push and pop in the same cycle while full is legal: the write lands in
// the slot the pop is vacating.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~flush;
  assign do_pop_s  = pop & ~flush & (count_r != CW'(0));

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else if (flush) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));

  prefetch_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .count (count_r)
  );

endmodule

// File: rtl/prefetch_fifo_chk.sv
// Assertion checker for prefetch_fifo.
// Ports: clk, rst_n, raw push/pop/flush requests and the current count.
module prefetch_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   push,
  input logic                   pop,
  input logic                   flush,
  input logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;

  // A push without a same-cycle pop must find a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop && !flush) |-> (count < CW'(DEPTH)));

  // A pop is only requested while an entry is present.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (pop && !flush) |-> (count != CW'(0)));

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF stage.
// Issues sequential word-address fetches (one outstanding at most), buffers
// {pc, inst} in prefetch_fifo, presents the head via valid/ready, flushes on
// redirect and stops fetching after the halt word is fetched.
// Ports: clk, rst_n (async, active-low), bus (inst_prefetch_queue_if.master).
// Optional: define INST_PREFETCH_QUEUE_STATS_EN to add the saturating
// counters stat_fetches (accepted acks) and stat_flushes (redirect cycles).
module inst_prefetch_queue
  import risc_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input logic                  clk,
  input logic                  rst_n,
  inst_prefetch_queue_if.master bus
`ifdef INST_PREFETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]          stat_fetches,
  output logic [31:0]          stat_flushes
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_r;
  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   mem_addr_r;
  logic              mem_req_r;
  logic              halted_r;
  logic              push_s;
  logic              pop_s;
  logic [2*XLEN-1:0] head_s;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  // Only an ack to a live (non-draining, non-redirected) request is kept.
  assign push_s = (state_r == REQ) & bus.mem_ack & ~bus.redirect;
  assign pop_s  = bus.out_ready & ~fifo_empty_s;

  // Fetch FSM. A request is only issued while the FIFO has a free slot and
  // no other request is outstanding, so the slot stays reserved until the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      mem_addr_r <= RESET_PC;
      mem_req_r  <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc;
          end else if (!fifo_full_s) begin
            mem_req_r  <= 1'b1;
            mem_addr_r <= fetch_pc_r;
            state_r    <= REQ;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc;
            if (bus.mem_ack) begin
              mem_req_r <= 1'b0;
              state_r   <= IDLE;
            end else begin
              state_r <= DRAIN;
            end
          end else if (bus.mem_ack) begin
            mem_req_r  <= 1'b0;
            fetch_pc_r <= fetch_pc_r + 32'd1;
            if (bus.mem_rdata == HALT_WORD) begin
              halted_r <= 1'b1;
              state_r  <= HALT;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        DRAIN: begin
          // The stale request must still complete on the bus; its data is dropped.
          if (bus.redirect) fetch_pc_r <= bus.redirect_pc;
          if (bus.mem_ack) begin
            mem_req_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        HALT: begin
          if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc;
            halted_r   <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
          halted_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(2 * XLEN)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.redirect),
    .din   ({mem_addr_r, bus.mem_rdata}),
    .head  (head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.halted    = halted_r;
  assign bus.out_valid = (fifo_count_s != CW'(0));
  assign bus.out_pc    = head_s[2*XLEN-1:XLEN];
  assign bus.out_inst  = head_s[XLEN-1:0];

`ifdef INST_PREFETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetches_r;
  logic [31:0] stat_flushes_r;

  // Saturating event counters for accepted fetches and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetches_r <= 32'd0;
      stat_flushes_r <= 32'd0;
    end else begin
      if (push_s)       stat_fetches_r <= sat_inc32(stat_fetches_r);
      if (bus.redirect) stat_flushes_r <= sat_inc32(stat_flushes_r);
    end
  end

  assign stat_fetches = stat_fetches_r;
  assign stat_flushes = stat_flushes_r;
`endif

endmodule
